// File: rtl/jtcontra_irqctrl.sv
// rtl/jtcontra_irqctrl.sv - N-source edge/level interrupt controller with mask, pending and priority vector
module jtcontra_irqctrl #(
   parameter int         N     = 4,
   parameter logic [7:0] POL   = 8'h00,
   parameter logic [7:0] MASK0 = 8'hFF,
   parameter logic [7:0] MODE0 = 8'hFF
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         cen,
   input  logic [N-1:0] src,
   input  logic         gate,
   input  logic         cs,
   input  logic [1:0]   addr,
   input  logic         rnw,
   input  logic [7:0]   din,
   output logic [7:0]   dout,
   input  logic         irq_ack,
   output logic         irq_n,
   output logic [2:0]   irq_id
);

   logic [N-1:0] r_mask;
   logic [N-1:0] r_mode;
   logic [N-1:0] r_pend;
   logic [N-1:0] r_act_last;
   logic         r_irq_n;
   logic [2:0]   r_irq_id;
   logic [7:0]   r_dout;

   logic [N-1:0] w_act;
   logic [N-1:0] w_set;
   logic [N-1:0] w_req;
   logic [N-1:0] w_w1c;
   logic [N-1:0] w_ack_clr;
   logic [N-1:0] w_pend_nx;
   logic         w_wr;
   logic [2:0]   w_id;
   logic [7:0]   w_rd;

   // Sources normalised to active-high; edges qualified by gate, but act_last always tracks
   assign w_act = ~(src ^ POL[N-1:0]);
   assign w_set = w_act & ~r_act_last & {N{gate}};
   assign w_req = r_pend & r_mask;
   assign w_wr  = cs & ~rnw & cen;

   // Clear sources: write-1-clear on addr 2 and the ack aimed at the currently reported source
   always_comb begin
      w_w1c     = '0;
      w_ack_clr = '0;
      if (w_wr && addr == 2'd2) w_w1c = din[N-1:0];
      for (int i = 0; i < N; i++) begin
         if (r_irq_id == 3'(i)) w_ack_clr[i] = irq_ack & ~r_irq_n & r_mode[i];
      end
   end

   // Edge bits hold until cleared (a new edge beats a clear); level bits mirror the gated source
   assign w_pend_nx = (r_mode & ((r_pend & ~w_w1c & ~w_ack_clr) | w_set)) |
                      (~r_mode & w_act & {N{gate}});

   // Fixed priority: lowest requesting index wins, 0 when nothing requests
   always_comb begin
      w_id = 3'd0;
      for (int i = N - 1; i >= 0; i--) begin
         if (w_req[i]) w_id = 3'(i);
      end
   end

   // Read mux; unused upper bits return 0, deselected window returns FF
   always_comb begin
      w_rd = 8'hFF;
      if (cs) begin
         w_rd = 8'h00;
         case (addr)
            2'd0:    w_rd[N-1:0] = r_mask;
            2'd1:    w_rd[N-1:0] = r_mode;
            2'd2:    w_rd[N-1:0] = r_pend;
            default: w_rd = {~r_irq_n, 4'b0000, r_irq_id};
         endcase
      end
   end

   // Register window writes, pending/edge tracking and registered CPU-facing outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         r_mask     <= MASK0[N-1:0];
         r_mode     <= MODE0[N-1:0];
         r_pend     <= '0;
         r_act_last <= '0;
         r_irq_n    <= 1'b1;
         r_irq_id   <= 3'd0;
         r_dout     <= 8'hFF;
      end else begin
         if (w_wr && addr == 2'd0) r_mask <= din[N-1:0];
         if (w_wr && addr == 2'd1) r_mode <= din[N-1:0];
         r_pend     <= w_pend_nx;
         r_act_last <= w_act;
         r_irq_n    <= ~|w_req;
         r_irq_id   <= w_id;
         r_dout     <= w_rd;
      end
   end

   assign dout   = r_dout;
   assign irq_n  = r_irq_n;
   assign irq_id = r_irq_id;

endmodule

// File: tb/tb_jtcontra_irqctrl.sv
// tb/tb_jtcontra_irqctrl.sv - directed self-checking bench for jtcontra_irqctrl
`timescale 1ns/1ps
module tb_jtcontra_irqctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       cen = 1'b1;
   logic [3:0] src = 4'hF;
   logic       gate = 1'b1;
   logic       cs = 1'b0;
   logic [1:0] addr = 2'd0;
   logic       rnw = 1'b1;
   logic [7:0] din = 8'h00;
   logic [7:0] dout;
   logic       irq_ack = 1'b0;
   logic       irq_n;
   logic [2:0] irq_id;

   int n_cmp = 0;
   int n_err = 0;
   logic [7:0] rd;

   jtcontra_irqctrl #(.N(4), .POL(8'h00), .MASK0(8'hFF), .MODE0(8'hFF)) dut (
      .clk(clk), .rst(rst), .cen(cen), .src(src), .gate(gate),
      .cs(cs), .addr(addr), .rnw(rnw), .din(din), .dout(dout),
      .irq_ack(irq_ack), .irq_n(irq_n), .irq_id(irq_id)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr_reg(input logic [1:0] a, input logic [7:0] d);
      cs = 1'b1; rnw = 1'b0; addr = a; din = d;
      tick();
      cs = 1'b0; rnw = 1'b1;
   endtask

   task automatic rd_reg(input logic [1:0] a, output logic [7:0] d);
      cs = 1'b1; rnw = 1'b1; addr = a;
      tick();
      d = dout;
      cs = 1'b0;
   endtask

   task automatic pulse_ack();
      irq_ack = 1'b1;
      tick();
      irq_ack = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL reset_irq_n got %b want 1", irq_n); end
      n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL reset_irq_id got %0d want 0", irq_id); end
      n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL reset_dout got %h want ff", dout); end
      rd_reg(2'd0, rd);
      n_cmp++; if (rd !== 8'h0F) begin n_err++; $display("FAIL reset_mask got %h want 0f", rd); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL reset_pending got %h want 00", rd); end
      tick();
      n_cmp++; if (dout !== 8'hFF) begin n_err++; $display("FAIL deselect_dout got %h want ff", dout); end
   endtask

   task automatic test_single_edge();
      src = 4'b1011; tick(); src = 4'hF;
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL edge_latency got %b want 1", irq_n); end
      tick();
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL edge_irq_n got %b want 0", irq_n); end
      n_cmp++; if (irq_id !== 3'd2) begin n_err++; $display("FAIL edge_irq_id got %0d want 2", irq_id); end
      rd_reg(2'd3, rd);
      n_cmp++; if (rd !== 8'h82) begin n_err++; $display("FAIL edge_status got %h want 82", rd); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h04) begin n_err++; $display("FAIL edge_pending got %h want 04", rd); end
      pulse_ack(); tick();
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL edge_ack_irq_n got %b want 1", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL edge_ack_pending got %h want 00", rd); end
   endtask

   task automatic test_priority();
      src = 4'b0101; tick(); src = 4'hF; tick();
      n_cmp++; if (irq_id !== 3'd1) begin n_err++; $display("FAIL prio_first_id got %0d want 1", irq_id); end
      pulse_ack(); tick();
      n_cmp++; if (irq_id !== 3'd3) begin n_err++; $display("FAIL prio_second_id got %0d want 3", irq_id); end
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL prio_second_irq_n got %b want 0", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h08) begin n_err++; $display("FAIL prio_pending got %h want 08", rd); end
      pulse_ack(); tick();
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL prio_done_irq_n got %b want 1", irq_n); end
   endtask

   task automatic test_level();
      wr_reg(2'd1, 8'h0E);
      src = 4'b1110; tick(); tick();
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL level_irq_n got %b want 0", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h01) begin n_err++; $display("FAIL level_pending got %h want 01", rd); end
      pulse_ack();
      wr_reg(2'd2, 8'h01);
      tick();
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL level_hold_irq_n got %b want 0", irq_n); end
      src = 4'hF; tick(); tick();
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL level_release_irq_n got %b want 1", irq_n); end
      wr_reg(2'd1, 8'h0F);
   endtask

   task automatic test_mask();
      wr_reg(2'd0, 8'h0B);
      src = 4'b1011; tick(); src = 4'hF; tick(); tick();
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL mask_irq_n got %b want 1", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h04) begin n_err++; $display("FAIL mask_pending got %h want 04", rd); end
      wr_reg(2'd0, 8'h0F);
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL unmask_latency got %b want 1", irq_n); end
      tick();
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL unmask_irq_n got %b want 0", irq_n); end
      n_cmp++; if (irq_id !== 3'd2) begin n_err++; $display("FAIL unmask_irq_id got %0d want 2", irq_id); end
      pulse_ack(); tick();
   endtask

   task automatic test_set_wins();
      src = 4'b1110; tick(); src = 4'hF; tick();
      n_cmp++; if (irq_id !== 3'd0) begin n_err++; $display("FAIL setwin_pre_id got %0d want 0", irq_id); end
      src = 4'b1110; irq_ack = 1'b1; tick();
      src = 4'hF; irq_ack = 1'b0; tick();
      n_cmp++; if (irq_n !== 1'b0) begin n_err++; $display("FAIL setwin_irq_n got %b want 0", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h01) begin n_err++; $display("FAIL setwin_pending got %h want 01", rd); end
      pulse_ack(); tick();
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL setwin_clear_irq_n got %b want 1", irq_n); end
   endtask

   task automatic test_gate_and_rst();
      gate = 1'b0; src = 4'b0111; tick(); tick();
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL gate_off_pending got %h want 00", rd); end
      gate = 1'b1; tick(); tick();
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL gate_late_pending got %h want 00", rd); end
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL gate_irq_n got %b want 1", irq_n); end
      src = 4'hF;
      wr_reg(2'd0, 8'h00);
      wr_reg(2'd1, 8'h05);
      src = 4'b1010; tick(); src = 4'hF; tick();
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h05) begin n_err++; $display("FAIL prerst_pending got %h want 05", rd); end
      rst = 1'b1; tick(); rst = 1'b0;
      n_cmp++; if (irq_n !== 1'b1) begin n_err++; $display("FAIL rst_irq_n got %b want 1", irq_n); end
      rd_reg(2'd2, rd);
      n_cmp++; if (rd !== 8'h00) begin n_err++; $display("FAIL rst_pending got %h want 00", rd); end
      rd_reg(2'd0, rd);
      n_cmp++; if (rd !== 8'h0F) begin n_err++; $display("FAIL rst_mask got %h want 0f", rd); end
      rd_reg(2'd1, rd);
      n_cmp++; if (rd !== 8'h0F) begin n_err++; $display("FAIL rst_mode got %h want 0f", rd); end
   endtask

   initial begin
      test_reset();
      test_single_edge();
      test_priority();
      test_level();
      test_mask();
      test_set_wins();
      test_gate_and_rst();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
